// File: rtl/gcd_bus_unit_if.sv
// CPU-side bus bundle for the GCD coprocessor: address, strobes, data and interrupt.
interface gcd_bus_unit_if;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic        irq;

  // The CPU side drives address, strobes and write data.
  modport master (
    output saddress, srd, swr, sdata_in,
    input  sdata_out, irq
  );

  // The coprocessor answers with read data and its interrupt.
  modport slave (
    input  saddress, srd, swr, sdata_in,
    output sdata_out, irq
  );
endinterface

// File: rtl/gcd_bus_unit.sv
// Memory-mapped GCD coprocessor: subtractive GCD, one step per clock, with
// start/abort control, sticky done/err/overrun flags and a level interrupt.
module gcd_bus_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [15:0] BASE_ADDR = 16'h00F8,
  parameter int          CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           n_reset,
  gcd_bus_unit_if.slave  bus
);

  localparam logic [15:0] ADDR_A1   = BASE_ADDR;
  localparam logic [15:0] ADDR_A2   = BASE_ADDR + 16'h0004;
  localparam logic [15:0] ADDR_W    = BASE_ADDR + 16'h0008;
  localparam logic [15:0] ADDR_S    = BASE_ADDR + 16'h000C;
  localparam logic [15:0] ADDR_CTRL = BASE_ADDR + 16'h0010;
  localparam logic [15:0] ADDR_CNT  = BASE_ADDR + 16'h0014;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [WIDTH-1:0]     r_a1, r_a2, r_w, r_a, r_b;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_done, r_err, r_overrun, r_ie;
  logic [31:0]          r_rdata;

  logic w_wrA1, w_wrA2, w_wrCtrl, w_rdW, w_rdS;
  logic w_start, w_abort, w_opZero, w_equal;
  logic w_busy, w_acceptStart, w_runStep, w_finish, w_overrunSet;
  logic [31:0] w_status, w_rdMux;

  assign w_wrA1   = bus.swr && (bus.saddress == ADDR_A1);
  assign w_wrA2   = bus.swr && (bus.saddress == ADDR_A2);
  assign w_wrCtrl = bus.swr && (bus.saddress == ADDR_CTRL);
  assign w_rdW    = bus.srd && (bus.saddress == ADDR_W);
  assign w_rdS    = bus.srd && (bus.saddress == ADDR_S);
  assign w_start  = w_wrCtrl && bus.sdata_in[0];
  assign w_abort  = w_wrCtrl && bus.sdata_in[1];
  assign w_opZero = (r_a1 == '0) || (r_a2 == '0);
  assign w_equal  = (r_a == r_b);

  // State register: only IDLE and RUN, abandoned immediately on reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // Next state: a start with two non-zero operands launches a run; abort or convergence ends it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start && !w_opZero) w_nextState = RUN;
      RUN:     if (w_abort || w_equal)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: abort outranks both a subtraction step and completion in RUN.
  always_comb begin
    w_busy        = (r_state == RUN);
    w_acceptStart = (r_state == IDLE) && w_start;
    w_runStep     = (r_state == RUN) && !w_abort && !w_equal;
    w_finish      = (r_state == RUN) && !w_abort && w_equal;
    w_overrunSet  = (r_state == RUN) && w_start && !w_abort;
  end

  // Operand, working, result, counter and flag registers; flag sets beat read-clears.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a1      <= '0;
      r_a2      <= '0;
      r_w       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      if (w_wrA1)   r_a1 <= bus.sdata_in[WIDTH-1:0];
      if (w_wrA2)   r_a2 <= bus.sdata_in[WIDTH-1:0];
      if (w_wrCtrl) r_ie <= bus.sdata_in[2];
      if (w_rdW)    r_done <= 1'b0;
      if (w_rdS)    r_overrun <= 1'b0;
      if (w_overrunSet) r_overrun <= 1'b1;
      if (w_acceptStart) begin
        r_a   <= r_a1;
        r_b   <= r_a2;
        r_cnt <= '0;
        r_err <= (r_a1 == '0) && (r_a2 == '0);
        if (w_opZero) begin
          r_w    <= r_a1 | r_a2;
          r_done <= 1'b1;
        end else begin
          r_done <= 1'b0;
        end
      end else if (w_runStep) begin
        if (r_a > r_b) r_a <= r_a - r_b;
        else           r_b <= r_b - r_a;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end else if (w_finish) begin
        r_w    <= r_a;
        r_done <= 1'b1;
      end
    end
  end

  assign w_status = {28'b0, w_busy, r_done, r_err, r_overrun};

  // Read multiplexer: unmapped addresses read as zero.
  always_comb begin
    w_rdMux = '0;
    case (bus.saddress)
      ADDR_A1:   w_rdMux = 32'(r_a1);
      ADDR_A2:   w_rdMux = 32'(r_a2);
      ADDR_W:    w_rdMux = 32'(r_w);
      ADDR_S:    w_rdMux = w_status;
      ADDR_CTRL: w_rdMux = {29'b0, r_ie, 2'b0};
      ADDR_CNT:  w_rdMux = 32'(r_cnt);
      default:   w_rdMux = '0;
    endcase
  end

  // Read data is captured on the read strobe and held until the next read.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)     r_rdata <= '0;
    else if (bus.srd) r_rdata <= w_rdMux;
  end

  assign bus.sdata_out = r_rdata;
  assign bus.irq       = r_done & r_ie;

endmodule

// File: tb/tb_gcd_bus_unit.sv
// Scoreboard bench for gcd_bus_unit: a 32-bit and an 8-bit instance driven over the bus.
module tb_gcd_bus_unit;

  localparam logic [15:0] BASE   = 16'h00F8;
  localparam logic [15:0] A_A1   = BASE + 16'h00;
  localparam logic [15:0] A_A2   = BASE + 16'h04;
  localparam logic [15:0] A_W    = BASE + 16'h08;
  localparam logic [15:0] A_S    = BASE + 16'h0C;
  localparam logic [15:0] A_CTRL = BASE + 16'h10;
  localparam logic [15:0] A_CNT  = BASE + 16'h14;
  localparam logic [15:0] A_NONE = BASE + 16'h18;

  typedef struct {
    logic [31:0] w;
    logic [31:0] cnt;
    logic [31:0] s;
  } exp_t;

  logic clk;
  logic n_reset;
  int   checkCount;
  int   passCount;
  exp_t expQ[$];

  gcd_bus_unit_if bus32();
  gcd_bus_unit_if bus8();

  gcd_bus_unit dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus32.slave)
  );

  gcd_bus_unit #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Independent subtractive GCD reference producing result, iteration count and final status.
  function automatic void modelGcd(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] w, output logic [31:0] cnt, output logic [31:0] s);
    cnt = 0;
    s   = 32'h4;
    if (a == 0 || b == 0) begin
      w = a | b;
      if (a == 0 && b == 0) s = 32'h6;
    end else begin
      while (a != b) begin
        if (a > b) a = a - b;
        else       b = b - a;
        cnt++;
      end
      w = a;
    end
  endfunction

  // Bus accesses start at a falling edge and return at the following falling edge.
  task automatic busWrite(input bit u8, input logic [15:0] addr, input logic [31:0] data);
    if (u8) begin bus8.saddress = addr; bus8.sdata_in = data; bus8.swr = 1'b1; end
    else    begin bus32.saddress = addr; bus32.sdata_in = data; bus32.swr = 1'b1; end
    @(negedge clk);
    if (u8) bus8.swr = 1'b0;
    else    bus32.swr = 1'b0;
  endtask

  task automatic busRead(input bit u8, input logic [15:0] addr, output logic [31:0] data);
    if (u8) begin bus8.saddress = addr; bus8.srd = 1'b1; end
    else    begin bus32.saddress = addr; bus32.srd = 1'b1; end
    @(negedge clk);
    if (u8) begin bus8.srd = 1'b0; data = bus8.sdata_out; end
    else    begin bus32.srd = 1'b0; data = bus32.sdata_out; end
  endtask

  task automatic readCheck(input bit u8, input logic [15:0] addr, input string tag, input logic [31:0] expected);
    logic [31:0] d;
    busRead(u8, addr, d);
    checkOutput(tag, d, expected);
  endtask

  // Loads operands and writes start (with ie); optionally pushes the model's prediction.
  task automatic applyStimulus(input bit u8, input logic [31:0] a1, input logic [31:0] a2,
                               input bit ie, input bit expectResult);
    exp_t e;
    logic [31:0] mask;
    mask = u8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    busWrite(u8, A_A1, a1);
    busWrite(u8, A_A2, a2);
    if (expectResult) begin
      modelGcd(a1 & mask, a2 & mask, e.w, e.cnt, e.s);
      expQ.push_back(e);
    end
    busWrite(u8, A_CTRL, {29'b0, ie, 2'b01});
  endtask

  // Polls status until busy drops, with a bounded number of reads.
  task automatic waitDone(input bit u8, output int busyCount, output logic [31:0] sFinal);
    logic [31:0] d;
    bit finished;
    busyCount = 0;
    finished  = 1'b0;
    sFinal    = '0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      busRead(u8, A_S, d);
      if (d[3]) busyCount++;
      else begin finished = 1'b1; sFinal = d; end
    end
    if (!finished) checkOutput("timeout", 32'd0, 32'd1);
  endtask

  // Pops the oldest prediction and compares status, result and iteration count.
  task automatic compareResult(input bit u8, input string tag, input logic [31:0] sFinal);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_S"}, sFinal, e.s);
      readCheck(u8, A_W, {tag, "_W"}, e.w);
      readCheck(u8, A_CNT, {tag, "_CNT"}, e.cnt);
    end
  endtask

  // Test sequence following the coprocessor's main use cases and corner cases.
  initial begin
    int busyCount;
    logic [31:0] sFinal;
    checkCount = 0;
    passCount  = 0;
    n_reset = 1'b0;
    bus32.saddress = '0; bus32.srd = 1'b0; bus32.swr = 1'b0; bus32.sdata_in = '0;
    bus8.saddress  = '0; bus8.srd  = 1'b0; bus8.swr  = 1'b0; bus8.sdata_in  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sdata_out", bus32.sdata_out, 32'd0);
    checkOutput("rst_irq", {31'b0, bus32.irq}, 32'd0);
    n_reset = 1'b1;
    @(negedge clk);
    readCheck(0, A_A1, "rst_A1", 32'd0);
    readCheck(0, A_A2, "rst_A2", 32'd0);
    readCheck(0, A_W, "rst_W", 32'd0);
    readCheck(0, A_S, "rst_S", 32'd0);
    readCheck(0, A_CTRL, "rst_CTRL", 32'd0);
    readCheck(0, A_CNT, "rst_CNT", 32'd0);

    $display("[TB] gcd(12,8)");
    applyStimulus(0, 32'd12, 32'd8, 1'b0, 1'b1);
    waitDone(0, busyCount, sFinal);
    checkOutput("g12_busy_cycles", busyCount, 32'd3);
    compareResult(0, "g12", sFinal);
    readCheck(0, A_S, "g12_S_after_readW", 32'h0);

    $display("[TB] abort with ie=1");
    applyStimulus(0, 32'd1000, 32'd1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    busWrite(0, A_CTRL, 32'h6);
    readCheck(0, A_S, "abort_S", 32'h0);
    readCheck(0, A_W, "abort_W_kept", 32'd4);
    readCheck(0, A_CNT, "abort_CNT", 32'd10);
    checkOutput("abort_irq", {31'b0, bus32.irq}, 32'd0);
    readCheck(0, A_CTRL, "abort_CTRL_ie", 32'h4);

    $display("[TB] zero operands");
    applyStimulus(0, 32'd0, 32'd5, 1'b1, 1'b1);
    waitDone(0, busyCount, sFinal);
    checkOutput("z05_busy_cycles", busyCount, 32'd0);
    checkOutput("z05_irq_set", {31'b0, bus32.irq}, 32'd1);
    compareResult(0, "z05", sFinal);
    checkOutput("z05_irq_clr", {31'b0, bus32.irq}, 32'd0);
    applyStimulus(0, 32'd0, 32'd0, 1'b0, 1'b1);
    waitDone(0, busyCount, sFinal);
    checkOutput("z00_irq_masked", {31'b0, bus32.irq}, 32'd0);
    compareResult(0, "z00", sFinal);

    $display("[TB] overrun");
    applyStimulus(0, 32'd1000, 32'd1, 1'b0, 1'b1);
    @(negedge clk);
    busWrite(0, A_CTRL, 32'h1);
    readCheck(0, A_S, "ovr_S_set", 32'h9);
    readCheck(0, A_S, "ovr_S_cleared", 32'h8);
    waitDone(0, busyCount, sFinal);
    compareResult(0, "ovr", sFinal);

    $display("[TB] reset mid-run");
    applyStimulus(0, 32'd1000, 32'd1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    readCheck(0, A_S, "mid_S_busy", 32'h8);
    n_reset = 1'b0;
    #2;
    checkOutput("mid_rst_sdata_out", bus32.sdata_out, 32'd0);
    checkOutput("mid_rst_irq", {31'b0, bus32.irq}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    readCheck(0, A_A1, "mid_A1", 32'd0);
    readCheck(0, A_A2, "mid_A2", 32'd0);
    readCheck(0, A_W, "mid_W", 32'd0);
    readCheck(0, A_S, "mid_S", 32'd0);
    readCheck(0, A_CTRL, "mid_CTRL", 32'd0);
    readCheck(0, A_CNT, "mid_CNT", 32'd0);
    applyStimulus(0, 32'd21, 32'd14, 1'b0, 1'b1);
    waitDone(0, busyCount, sFinal);
    compareResult(0, "g21", sFinal);
    busWrite(0, A_W, 32'hDEAD);
    readCheck(0, A_W, "ro_W_write_ignored", 32'd7);
    readCheck(0, A_NONE, "unmapped32", 32'd0);

    $display("[TB] WIDTH=8 instance");
    applyStimulus(1, 32'h1FF, 32'h33, 1'b0, 1'b1);
    readCheck(1, A_A1, "w8_A1", 32'h0000_00FF);
    waitDone(1, busyCount, sFinal);
    compareResult(1, "w8", sFinal);
    readCheck(1, A_NONE, "unmapped8", 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
